person_frame_draw: RTL

- Consumer of the 5-bit person-selection code produced by the grid selector; decodes it back to one of the 3x3 portrait tiles.
- Overlays a coloured highlight frame on that tile in the VGA pixel stream.
- Sits in the draw chain after the background/portrait stage and before the mouse pointer stage.
- Code is sampled only at frame boundaries (no tearing); a newly chosen tile flashes for a fixed number of frames, then stays steady.

---
 rtl/person_frame_draw.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/person_frame_draw.sv
// Highlight frame overlay for the selected 3x3 portrait tile; the selection code is taken only at frame boundaries.
// Optional build macro PERSON_FRAME_BLINK_EN adds a FLASH state that blinks a newly chosen tile before it turns steady.
module person_frame_draw #(
  parameter int          FRAME_W      = 4,
  parameter logic [11:0] FRAME_COLOR  = 12'hF00
`ifdef PERSON_FRAME_BLINK_EN
  ,
  parameter int          BLINK_PERIOD = 8,
  parameter int          FLASH_FRAMES = 48
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  your_person,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        sel_valid
);

  // Tile geometry of the portrait grid (origins and extent of each tile).
  localparam logic [11:0] X_1_DIM = 12'd100;
  localparam logic [11:0] X_2_DIM = 12'd310;
  localparam logic [11:0] X_3_DIM = 12'd520;
  localparam logic [11:0] Y_1_DIM = 12'd50;
  localparam logic [11:0] Y_2_DIM = 12'd210;
  localparam logic [11:0] Y_3_DIM = 12'd370;
  localparam logic [11:0] A_SIDE  = 12'd200;
  localparam logic [11:0] B_SIDE  = 12'd150;
  localparam logic [11:0] FW_M1   = 12'(FRAME_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLASH  = 2'd1,
    S_STEADY = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_col;
  logic [1:0] r_row;
  logic       r_visible;
  logic       r_vblnk_prev;

  logic [1:0]  w_col;
  logic [1:0]  w_row;
  logic        w_valid;
  logic        w_same;
  logic        w_boundary;
  logic [11:0] w_x;
  logic [11:0] w_y;
  logic [11:0] w_h;
  logic [11:0] w_v;
  logic        w_in_box;
  logic        w_near_edge;
  logic        w_frame_px;

  // Thermometer-style code from the selector; col/row value 0 means no tile.
  always_comb begin
    w_col = 2'd0;
    w_row = 2'd0;
    case (your_person)
      5'b00001: begin w_col = 2'd1; w_row = 2'd1; end
      5'b00011: begin w_col = 2'd2; w_row = 2'd1; end
      5'b00111: begin w_col = 2'd3; w_row = 2'd1; end
      5'b01111: begin w_col = 2'd1; w_row = 2'd2; end
      5'b11111: begin w_col = 2'd2; w_row = 2'd2; end
      5'b11110: begin w_col = 2'd3; w_row = 2'd2; end
      5'b11100: begin w_col = 2'd1; w_row = 2'd3; end
      5'b11000: begin w_col = 2'd2; w_row = 2'd3; end
      5'b10000: begin w_col = 2'd3; w_row = 2'd3; end
      default:  begin w_col = 2'd0; w_row = 2'd0; end
    endcase
  end

  assign w_valid    = (w_col != 2'd0);
  assign w_same     = (w_col == r_col) && (w_row == r_row);
  assign w_boundary = vblnk_in & ~r_vblnk_prev;

  always_comb begin
    w_x = 12'd0;
    w_y = 12'd0;
    case (r_col)
      2'd1:    w_x = X_1_DIM;
      2'd2:    w_x = X_2_DIM;
      2'd3:    w_x = X_3_DIM;
      default: w_x = 12'd0;
    endcase
    case (r_row)
      2'd1:    w_y = Y_1_DIM;
      2'd2:    w_y = Y_2_DIM;
      2'd3:    w_y = Y_3_DIM;
      default: w_y = 12'd0;
    endcase
  end

  assign w_h         = {1'b0, hcount_in};
  assign w_v         = {1'b0, vcount_in};
  assign w_in_box    = (w_h >= w_x) && (w_h <= w_x + A_SIDE) &&
                       (w_v >= w_y) && (w_v <= w_y + B_SIDE);
  assign w_near_edge = (w_h <= w_x + FW_M1) || (w_h >= w_x + A_SIDE - FW_M1) ||
                       (w_v <= w_y + FW_M1) || (w_v >= w_y + B_SIDE - FW_M1);
  assign w_frame_px  = (r_state != S_IDLE) && r_visible && w_in_box && w_near_edge;

`ifdef PERSON_FRAME_BLINK_EN
  localparam int CW = $clog2(FLASH_FRAMES + 1);
  logic [CW-1:0] r_frame_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_blink_odd;
  assign w_cnt_inc   = r_frame_cnt + CW'(1);
  assign w_blink_odd = ((int'(w_cnt_inc) / BLINK_PERIOD) % 2) == 1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col        <= 2'd0;
      r_row        <= 2'd0;
      r_visible    <= 1'b0;
      r_vblnk_prev <= 1'b0;
      hcount_out   <= 11'd0;
      hsync_out    <= 1'b0;
      hblnk_out    <= 1'b0;
      vcount_out   <= 11'd0;
      vsync_out    <= 1'b0;
      vblnk_out    <= 1'b0;
      rgb_out      <= 12'h000;
      sel_valid    <= 1'b0;
`ifdef PERSON_FRAME_BLINK_EN
      r_frame_cnt  <= '0;
`endif
    end else begin
      r_vblnk_prev <= vblnk_in;
      hcount_out   <= hcount_in;
      hsync_out    <= hsync_in;
      hblnk_out    <= hblnk_in;
      vcount_out   <= vcount_in;
      vsync_out    <= vsync_in;
      vblnk_out    <= vblnk_in;
      rgb_out      <= (w_frame_px && !hblnk_in && !vblnk_in) ? FRAME_COLOR : rgb_in;

      if (w_boundary) begin
        if (!w_valid) begin
          r_state   <= S_IDLE;
          r_col     <= 2'd0;
          r_row     <= 2'd0;
          r_visible <= 1'b0;
          sel_valid <= 1'b0;
`ifdef PERSON_FRAME_BLINK_EN
          r_frame_cnt <= '0;
`endif
        end else if (!w_same || r_state == S_IDLE) begin
          r_col     <= w_col;
          r_row     <= w_row;
          r_visible <= 1'b1;
          sel_valid <= 1'b1;
`ifdef PERSON_FRAME_BLINK_EN
          r_state     <= S_FLASH;
          r_frame_cnt <= '0;
`else
          r_state     <= S_STEADY;
`endif
        end
`ifdef PERSON_FRAME_BLINK_EN
        else if (r_state == S_FLASH) begin
          // The counter names the frame now ending; the next frame uses the incremented value.
          if (r_frame_cnt == CW'(FLASH_FRAMES - 1)) begin
            r_state   <= S_STEADY;
            r_visible <= 1'b1;
          end else begin
            r_frame_cnt <= w_cnt_inc;
            r_visible   <= ~w_blink_odd;
          end
        end
`endif
      end
    end
  end

endmodule
